// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, arbiter state encoding and
// the state-to-grant mapping used by the two-master arbiter.
package wb_pkg;

    localparam int WB_AW = 16;
    localparam int WB_DW = 16;

    // The encoding is chosen so that each grant state already matches its one-hot gnt value
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    // One-hot grant vector for a given arbiter state; 00 when idle
    function automatic logic [1:0] state_to_gnt(arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            GNT0:    g = 2'b01;
            GNT1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus stall watchdog: counts consecutive stalled strobe cycles and flags a
// timeout in the cycle where the count reaches TIMEOUT-1 with the bus still
// stalled. TIMEOUT=0 disables it. Reusable by any bridge that needs a
// forced ERR on a hung slave.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic stall,
    output logic timeout
);

    localparam bit ENABLED = (TIMEOUT > 0);
    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CW-1:0] count_q;

    // Timeout fires combinationally in the stalled cycle that hits the limit
    always_comb begin
        timeout = ENABLED && stall && (count_q == LAST);
    end

    // Stall counter; restarts on any non-stall cycle, external clear or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else if (!ENABLED || clr || !stall || timeout) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic-cycle arbiter in front of one slave bus.
// The grant is registered and held for the whole CYC of the winner; ties
// from idle alternate via the last-served master so neither master starves.
// A stalled slave is terminated with ERR by the embedded watchdog.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_w,
    output logic [DW-1:0] m0_dat_r,
    output logic          m0_ack,
    output logic          m0_err,

    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_w,
    output logic [DW-1:0] m1_dat_r,
    output logic          m1_ack,
    output logic          m1_err,

    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_w,
    input  logic [DW-1:0] s_dat_r,
    input  logic          s_ack,
    input  logic          s_err,

    output logic [1:0]    gnt
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;   // index of the master served most recently
    logic       wd_stall;
    logic       wd_clr;
    logic       wd_err;

    // Read data is shared by both masters; only ack/err qualify it
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;
    assign gnt      = state_to_gnt(state_q);

    // State and last-served registers; last starts at 1 so master 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: round-robin pick from idle, release and direct handoff from a grant
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    state_d = GNT0;
                end else if (m1_cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mux: granted master drives the slave, slave terminations go back to it only
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
                m0_ack  = s_ack;
                m0_err  = s_err | wd_err;
            end
            GNT1: begin
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
                m1_ack  = s_ack;
                m1_err  = s_err | wd_err;
            end
            default: begin
            end
        endcase
    end

    // A stall is a strobed cycle with no slave termination; a grant change restarts the count
    assign wd_stall = s_stb & ~s_ack & ~s_err;
    assign wd_clr   = (state_d != state_q);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .stall   (wd_stall),
        .timeout (wd_err)
    );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2. The main instance uses TIMEOUT=4; a second
// instance with TIMEOUT=0 shares every input and is used to confirm that
// the watchdog can be disabled.
module tb_wb_arbiter2;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [15:0] m0_adr, m0_dat_w;
    logic        m1_cyc, m1_stb, m1_we;
    logic [15:0] m1_adr, m1_dat_w;
    logic [15:0] s_dat_r;
    logic        s_ack, s_err;

    logic [15:0] m0_dat_r, m1_dat_r;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [15:0] s_adr, s_dat_w;
    logic [1:0]  gnt;

    logic [15:0] n_m0_dat_r, n_m1_dat_r;
    logic        n_m0_ack, n_m0_err, n_m1_ack, n_m1_err;
    logic        n_s_cyc, n_s_stb, n_s_we;
    logic [15:0] n_s_adr, n_s_dat_w;
    logic [1:0]  n_gnt;

    int vectors;
    int miscompares;

    wb_arbiter2 #(.AW(16), .DW(16), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .gnt(gnt)
    );

    wb_arbiter2 #(.AW(16), .DW(16), .TIMEOUT(0)) u_dut_nowd (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_dat_r(n_m0_dat_r), .m0_ack(n_m0_ack), .m0_err(n_m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_dat_r(n_m1_dat_r), .m1_ack(n_m1_ack), .m1_err(n_m1_err),
        .s_cyc(n_s_cyc), .s_stb(n_s_stb), .s_we(n_s_we), .s_adr(n_s_adr), .s_dat_w(n_s_dat_w),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .gnt(n_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat_w = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat_w = '0;
        s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        s_dat_r = 16'h5A5A;
        rst_n = 1'b0;
        #12;
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rst_gnt got %b want 00", gnt); end
        vectors++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin miscompares++; $display("FAIL rst_s_ctl got %b want 000", {s_cyc, s_stb, s_we}); end
        vectors++; if (s_adr !== 16'h0000 || s_dat_w !== 16'h0000) begin miscompares++; $display("FAIL rst_s_bus got %h/%h want 0000/0000", s_adr, s_dat_w); end
        vectors++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin miscompares++; $display("FAIL rst_term got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        vectors++; if (m0_dat_r !== 16'h5A5A || m1_dat_r !== 16'h5A5A) begin miscompares++; $display("FAIL rst_dat_r got %h/%h want 5a5a", m0_dat_r, m1_dat_r); end
        rst_n = 1'b1;
        step();

        // Mid-transaction reset: m0 granted and stalled
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0042;
        step();
        vectors++; if (gnt !== 2'b01 || s_cyc !== 1'b1) begin miscompares++; $display("FAIL midrst_pre got gnt=%b s_cyc=%b want 01/1", gnt, s_cyc); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin miscompares++; $display("FAIL midrst_async got gnt=%b s_cyc=%b s_stb=%b want 00/0/0", gnt, s_cyc, s_stb); end
        vectors++; if (m0_ack !== 1'b0 || m0_err !== 1'b0) begin miscompares++; $display("FAIL midrst_term got ack=%b err=%b want 0/0", m0_ack, m0_err); end
        step();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL midrst_held got %b want 00", gnt); end
        rst_n = 1'b1;
        #1;
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL midrst_release got %b want 00", gnt); end
        step();
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL midrst_regrant got %b want 01", gnt); end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        step();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 16'h1234;
        #1;
        vectors++; if (gnt !== 2'b00 || s_cyc !== 1'b0) begin miscompares++; $display("FAIL rd_latency got gnt=%b s_cyc=%b want 00/0", gnt, s_cyc); end
        step();
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL rd_gnt got %b want 01", gnt); end
        vectors++; if (s_adr !== 16'h1234 || s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b0) begin miscompares++; $display("FAIL rd_sbus got adr=%h ctl=%b want 1234/110", s_adr, {s_cyc, s_stb, s_we}); end
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL rd_noack got %b want 0", m0_ack); end
        step();
        s_ack = 1'b1; s_dat_r = 16'hBEEF;
        #1;
        vectors++; if (m0_ack !== 1'b1 || m0_dat_r !== 16'hBEEF) begin miscompares++; $display("FAIL rd_ack got ack=%b dat=%h want 1/beef", m0_ack, m0_dat_r); end
        vectors++; if (m1_ack !== 1'b0 || m0_err !== 1'b0 || m1_err !== 1'b0) begin miscompares++; $display("FAIL rd_others got m1_ack=%b m0_err=%b m1_err=%b want 0/0/0", m1_ack, m0_err, m1_err); end
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        step();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rd_release got %b want 00", gnt); end
    endtask

    task automatic test_arbitration();
        do_reset();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL arb_first got %b want 01", gnt); end
        vectors++; if (m1_ack !== 1'b0 || m1_err !== 1'b0) begin miscompares++; $display("FAIL arb_loser got ack=%b err=%b want 0/0", m1_ack, m1_err); end
        m0_cyc = 1'b0;
        #1;
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL arb_release_cycle got %b want 01", gnt); end
        step();
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL arb_handoff got %b want 10", gnt); end
        m1_cyc = 1'b0;
        step();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL arb_idle got %b want 00", gnt); end
        // m1 served last, so a tie goes to m0
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL arb_alt0 got %b want 01", gnt); end
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        step();
        step();
        // m0 served last, so a tie goes to m1
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL arb_alt1 got %b want 10", gnt); end
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        step();
        step();
    endtask

    task automatic test_bus_lock();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0100;
        step();
        m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (gnt !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin miscompares++; $display("FAIL lock_xfer%0d got gnt=%b m0_ack=%b m1_ack=%b want 01/1/0", i, gnt, m0_ack, m1_ack); end
            step();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        #1;
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL lock_release_cycle got %b want 01", gnt); end
        step();
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL lock_handoff got %b want 10", gnt); end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        step();
    endtask

    task automatic test_write();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 16'h00FF; m1_dat_w = 16'hA5A5;
        step();
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL wr_gnt got %b want 10", gnt); end
        vectors++; if (s_we !== 1'b1 || s_adr !== 16'h00FF || s_dat_w !== 16'hA5A5) begin miscompares++; $display("FAIL wr_sbus got we=%b adr=%h dat=%h want 1/00ff/a5a5", s_we, s_adr, s_dat_w); end
        vectors++; if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL wr_noack got %b want 0", m1_ack); end
        s_ack = 1'b1;
        #1;
        vectors++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack got m1=%b m0=%b want 1/0", m1_ack, m0_ack); end
        s_ack = 1'b0;
        #1;
        vectors++; if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_fall got %b want 0", m1_ack); end
        s_err = 1'b1;
        #1;
        vectors++; if (m1_err !== 1'b1 || m0_err !== 1'b0) begin miscompares++; $display("FAIL wr_err got m1=%b m0=%b want 1/0", m1_err, m0_err); end
        s_err = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        step();
        step();
    endtask

    task automatic test_watchdog();
        int errs_main;
        int errs_nowd;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0DEA;
        step();
        // Stalled cycles 1..8: forced err only in the 4th and 8th
        for (int k = 1; k <= 8; k++) begin
            #1;
            vectors++; if (m0_err !== ((k == 4) || (k == 8))) begin miscompares++; $display("FAIL wd_cycle%0d got %b want %b", k, m0_err, ((k == 4) || (k == 8))); end
            step();
        end
        // Two stalls, strobe gap, then a fresh count of four
        step();
        step();
        m0_stb = 1'b0;
        step();
        m0_stb = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            vectors++; if (m0_err !== (k == 4)) begin miscompares++; $display("FAIL wd_gap_cycle%0d got %b want %b", k, m0_err, (k == 4)); end
            step();
        end
        // Long stall: main instance errs every 4th cycle, disabled instance never
        errs_main = 0;
        errs_nowd = 0;
        for (int k = 0; k < 1000; k++) begin
            #1;
            if (m0_err === 1'b1) errs_main++;
            if (n_m0_err === 1'b1) errs_nowd++;
            step();
        end
        vectors++; if (errs_main !== 250) begin miscompares++; $display("FAIL wd_long_count got %0d want 250", errs_main); end
        vectors++; if (errs_nowd !== 0) begin miscompares++; $display("FAIL wd_disabled got %0d want 0", errs_nowd); end
        vectors++; if (m1_err !== 1'b0 || n_gnt !== 2'b01) begin miscompares++; $display("FAIL wd_misc got m1_err=%b n_gnt=%b want 0/01", m1_err, n_gnt); end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        step();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL wd_release got %b want 00", gnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        s_dat_r = '0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_arbitration();
        test_bus_lock();
        test_write();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master Wishbone (classic cycle) arbiter sharing one 16-bit Wishbone slave bus.
- Typical masters: the J1 Wishbone bridge (master 0) and a debug/loader master (master 1), e.g. a UART program loader.
- Grant is registered and locked for the whole CYC. Priority is round-robin, so neither master can starve the other.
- A stalled slave cycle is terminated with ERR after a programmable number of cycles.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 255, max cycles STB may wait for ACK/ERR before the arbiter forces ERR. 0 = watchdog disabled.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write
- m0_adr  in  AW  master 0 address
- m0_dat_w  in  DW  master 0 write data
- m0_dat_r  out  DW  read data to master 0
- m0_ack, m0_err  out  1 each  termination to master 0
- m1_* (identical set to m0_*)  master 1
- s_cyc, s_stb, s_we  out  1 each  to slave
- s_adr  out  AW
- s_dat_w  out  DW
- s_dat_r  in  DW
- s_ack, s_err  in  1 each
- gnt  out  2  one-hot current grant, 00 when idle

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low.
  - On reset: state=IDLE, gnt=00, last=1 (master 0 wins the first tie), watchdog count=0.
  - At reset: all s_* outputs are 0, all m*_ack/m*_err are 0, m*_dat_r=s_dat_r (unconditionally routed).
  - Reset asserted mid-cycle aborts it immediately; no termination is delivered.
- FSM states: IDLE, GNT0, GNT1 (registered). gnt mirrors the state.
- IDLE:
  - Only m0_cyc -> GNT0. Only m1_cyc -> GNT1.
  - Both -> the master != last.
  - Arbitration latency is 1 cycle: a request in cycle N drives the slave from cycle N+1.
- GNTx:
  - Slave outputs are a combinational mux of master x.
  - mx_ack=s_ack, mx_err=s_err|wd_err.
  - The other master sees ack=err=0.
- Release:
  - When the granted master's cyc is sampled low, last<=x.
  - Next state is GNT(other) if the other cyc is high, else IDLE.
  - Handoff costs zero idle cycles beyond the cycle in which cyc is low.
  - A master holding cyc keeps the grant indefinitely; this is the bus lock and is intentional.
- Watchdog (TIMEOUT>0):
  - 8..16-bit counter, sized $clog2(TIMEOUT+1).
  - Increments each cycle in which s_stb=1 and s_ack=0 and s_err=0.
  - When count==TIMEOUT-1 and still no termination, wd_err=1 for that cycle (combinational), delivered to the granted master as err.
  - The counter clears on any ack/err/wd_err, on grant change, and when s_stb=0.
- Simultaneous s_ack and s_err are forwarded as-is; the slave must not do this, and the arbiter does not fix it.
- No outputs are registered other than gnt. The combinational path is master->slave and slave->master only, with no loops through state.

Decomposition:
- Package wb_pkg:
  - typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;
  - localparams WB_AW=16, WB_DW=16.
- Sub-module wb_watchdog (counter plus compare; inputs clk, rst_n, clr, stall; output timeout; parameter TIMEOUT). It is reusable by later bridges.

Test Plan:
- Reset mid-transaction: m0 granted, stb high, s_ack=0; pulse rst_n low -> gnt=00, s_cyc=0 asynchronously, no m0_ack/err; after release, m0 re-granted 1 cycle later.
- Single master read: m0_cyc=stb=1, adr=16'h1234, slave acks in 2nd granted cycle with 16'hBEEF -> gnt=01 at N+1, s_adr=16'h1234, m0_ack=1 with m0_dat_r=16'hBEEF, m1_ack=0.
- Simultaneous requests from IDLE after reset -> GNT0 first; m0 drops cyc -> next cycle gnt=10. Both request again from IDLE -> gnt=10 is not chosen; gnt=01 (alternation via last).
- Bus lock: m0 holds cyc for 5 transfers while m1 requests -> gnt stays 01 for all 5; gnt=10 in the cycle after m0_cyc falls.
- Watchdog: TIMEOUT=4, slave never acks -> m0_err=1 exactly in the 4th stb cycle, one cycle wide; count restarts; TIMEOUT=0 -> no err after 1000 cycles.
- Write pass-through: m1 write, adr=16'h00FF, dat=16'hA5A5 -> s_we=1, s_dat_w=16'hA5A5, m1_ack follows s_ack with zero delay.
